// File: rtl/multicycle_controller.sv
// Control FSM for the multicycle RISC-V core: sequences the shared ALU, unified
// memory port and register file, with a ready handshake for memory wait states.
module multicycle_controller #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         opcode,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               adr_src,
  output logic               mem_write,
  output logic               ir_write,
  output logic [1:0]         result_src,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic [1:0]         imm_src,
  output logic               reg_write,
  output logic               illegal_instr,
  output logic [STATE_W-1:0] state
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH     = STATE_W'(0),
    S_DECODE    = STATE_W'(1),
    S_MEM_ADR   = STATE_W'(2),
    S_MEM_READ  = STATE_W'(3),
    S_MEM_WB    = STATE_W'(4),
    S_MEM_WRITE = STATE_W'(5),
    S_EXECUTE_R = STATE_W'(6),
    S_EXECUTE_I = STATE_W'(7),
    S_ALU_WB    = STATE_W'(8),
    S_BEQ       = STATE_W'(9),
    S_JAL       = STATE_W'(10),
    S_ILLEGAL   = STATE_W'(11)
  } state_t;

  state_t state_q, state_d;
  logic   pc_update;
  logic   branch;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    pc_update     = 1'b0;
    branch        = 1'b0;
    adr_src       = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    result_src    = 2'b00;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    reg_write     = 1'b0;
    illegal_instr = 1'b0;

    case (opcode)
      OP_SW:   imm_src = 2'b01;
      OP_BEQ:  imm_src = 2'b10;
      OP_JAL:  imm_src = 2'b11;
      default: imm_src = 2'b00;
    endcase

    case (state_q)
      S_FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ready;
        pc_update  = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEM_ADR;
          OP_R:         state_d = S_EXECUTE_R;
          OP_I:         state_d = S_EXECUTE_I;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_ILLEGAL;
        endcase
      end
      S_MEM_ADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        if (opcode == OP_LW)      state_d = S_MEM_READ;
        else if (opcode == OP_SW) state_d = S_MEM_WRITE;
        else                      state_d = S_FETCH;
      end
      S_MEM_READ: begin
        adr_src = 1'b1;
        if (mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXECUTE_R: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        state_d   = S_ALU_WB;
      end
      S_EXECUTE_I: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        state_d   = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        branch    = 1'b1;
        state_d   = S_FETCH;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
        state_d   = S_ALU_WB;
      end
      S_ILLEGAL: begin
        illegal_instr = 1'b1;
        state_d       = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // Reset silences every strobe and select in the same cycle it is asserted
    if (reset) begin
      pc_update     = 1'b0;
      branch        = 1'b0;
      adr_src       = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      result_src    = 2'b00;
      alu_src_a     = 2'b00;
      alu_src_b     = 2'b00;
      alu_op        = 2'b00;
      imm_src       = 2'b00;
      reg_write     = 1'b0;
      illegal_instr = 1'b0;
      state_d       = S_FETCH;
    end

    pc_write = pc_update | (branch & zero);
  end

  assign state = reset ? '0 : state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle expected output vectors
// are queued as stimulus is applied and checked mid-cycle.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal_instr;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op, imm_src;
  logic [3:0] state;

  multicycle_controller #(.STATE_W(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .imm_src(imm_src), .reg_write(reg_write),
    .illegal_instr(illegal_instr), .state(state)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111;
  localparam logic [6:0] BAD = 7'b1110011;

  int n_cmp = 0;
  int n_err = 0;
  logic [19:0] sb[$];

  // {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b, alu_op, imm_src, reg_write, illegal_instr, state}
  function automatic logic [19:0] pk(input logic pcw, input logic adr, input logic mw, input logic irw,
                                     input logic [1:0] rs, input logic [1:0] asa, input logic [1:0] asb,
                                     input logic [1:0] aop, input logic [1:0] imm, input logic rw,
                                     input logic ill, input logic [3:0] st);
    return {pcw, adr, mw, irw, rs, asa, asb, aop, imm, rw, ill, st};
  endfunction

  function automatic logic [19:0] e_fetch(input logic mr, input logic [1:0] imm);
    return pk(mr, 0, 0, mr, 2'b10, 2'b00, 2'b10, 2'b00, imm, 0, 0, 4'd0);
  endfunction
  function automatic logic [19:0] e_decode(input logic [1:0] imm);
    return pk(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, imm, 0, 0, 4'd1);
  endfunction
  function automatic logic [19:0] e_memadr(input logic [1:0] imm);
    return pk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, imm, 0, 0, 4'd2);
  endfunction
  function automatic logic [19:0] e_aluwb(input logic [1:0] imm);
    return pk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, imm, 1, 0, 4'd8);
  endfunction

  task automatic cyc(input string tag, input logic rst, input logic [6:0] op, input logic z,
                     input logic mr, input logic [19:0] exp_v);
    logic [19:0] obs, e;
    reset = rst; opcode = op; zero = z; mem_ready = mr;
    sb.push_back(exp_v);
    @(negedge clk);
    obs = {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b,
           alu_op, imm_src, reg_write, illegal_instr, state};
    e = sb.pop_front();
    n_cmp++;
    assert (obs === e) else begin
      n_err++;
      $error("FAIL %s: observed %05h expected %05h", tag, obs, e);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; opcode = LW; zero = 1'b0; mem_ready = 1'b1;
    @(posedge clk); #1;
    cyc("reset", 1, LW, 0, 1, 20'h0);

    // lw, no wait states: 5 cycles
    cyc("lw_fetch",   0, LW, 0, 1, e_fetch(1, 2'b00));
    cyc("lw_decode",  0, LW, 0, 1, e_decode(2'b00));
    cyc("lw_memadr",  0, LW, 0, 1, e_memadr(2'b00));
    cyc("lw_memread", 0, LW, 0, 1, pk(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 4'd3));
    cyc("lw_memwb",   0, LW, 0, 1, pk(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 4'd4));

    // sw with one fetch wait and two write waits
    cyc("sw_fetch_wait", 0, SW, 0, 0, e_fetch(0, 2'b01));
    cyc("sw_fetch",      0, SW, 0, 1, e_fetch(1, 2'b01));
    cyc("sw_decode",     0, SW, 0, 1, e_decode(2'b01));
    cyc("sw_memadr",     0, SW, 0, 1, e_memadr(2'b01));
    cyc("sw_write_w1",   0, SW, 0, 0, pk(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 0, 0, 4'd5));
    cyc("sw_write_w2",   0, SW, 0, 0, pk(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 0, 0, 4'd5));
    cyc("sw_write_done", 0, SW, 0, 1, pk(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 0, 0, 4'd5));

    // R-type
    cyc("r_fetch",  0, RT, 0, 1, e_fetch(1, 2'b00));
    cyc("r_decode", 0, RT, 0, 1, e_decode(2'b00));
    cyc("r_exec",   0, RT, 0, 1, pk(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 0, 0, 4'd6));
    cyc("r_wb",     0, RT, 0, 1, e_aluwb(2'b00));

    // I-type
    cyc("i_fetch",  0, IT, 0, 1, e_fetch(1, 2'b00));
    cyc("i_decode", 0, IT, 0, 1, e_decode(2'b00));
    cyc("i_exec",   0, IT, 0, 1, pk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b10, 2'b00, 0, 0, 4'd7));
    cyc("i_wb",     0, IT, 0, 1, e_aluwb(2'b00));

    // beq taken (zero held high, must not leak into DECODE)
    cyc("beq_t_fetch",  0, BQ, 1, 1, e_fetch(1, 2'b10));
    cyc("beq_t_decode", 0, BQ, 1, 1, e_decode(2'b10));
    cyc("beq_t_beq",    0, BQ, 1, 1, pk(1, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01, 2'b10, 0, 0, 4'd9));
    // beq not taken
    cyc("beq_n_fetch",  0, BQ, 0, 1, e_fetch(1, 2'b10));
    cyc("beq_n_decode", 0, BQ, 0, 1, e_decode(2'b10));
    cyc("beq_n_beq",    0, BQ, 0, 1, pk(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01, 2'b10, 0, 0, 4'd9));

    // jal
    cyc("jal_fetch",  0, JL, 0, 1, e_fetch(1, 2'b11));
    cyc("jal_decode", 0, JL, 0, 1, e_decode(2'b11));
    cyc("jal_jal",    0, JL, 0, 1, pk(1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, 2'b11, 0, 0, 4'd10));
    cyc("jal_wb",     0, JL, 0, 1, e_aluwb(2'b11));

    // unsupported opcode
    cyc("ill_fetch",   0, BAD, 1, 1, e_fetch(1, 2'b00));
    cyc("ill_decode",  0, BAD, 1, 1, e_decode(2'b00));
    cyc("ill_illegal", 0, BAD, 1, 1, pk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1, 4'd11));

    // reset in the middle of a stalled store
    cyc("rst_sw_fetch",  0, SW, 0, 1, e_fetch(1, 2'b01));
    cyc("rst_sw_decode", 0, SW, 0, 1, e_decode(2'b01));
    cyc("rst_sw_memadr", 0, SW, 0, 1, e_memadr(2'b01));
    cyc("rst_sw_write",  0, SW, 0, 0, pk(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 0, 0, 4'd5));
    cyc("rst_sw_reset",  1, SW, 0, 0, 20'h0);
    cyc("rst_sw_after",  0, SW, 0, 0, e_fetch(0, 2'b01));
    cyc("rst_sw_after2", 0, SW, 0, 0, e_fetch(0, 2'b01));
    cyc("rst_sw_refetch", 0, LW, 0, 1, e_fetch(1, 2'b00));
    cyc("rst_sw_decode2", 0, LW, 0, 1, e_decode(2'b00));

    n_cmp++;
    assert (sb.size() == 0) else begin
      n_err++;
      $error("FAIL sb_drain: observed %0d expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
